// File: rtl/gemm_pkg.sv
// Shared types for the GEMM result path.
//   state_t : result packer sequencing states
//   line_t  : one packed 256-bit result line plus its end-of-tile marker
package gemm_pkg;

   localparam int RESULT_LANES  = 16;
   localparam int RESULT_ELEM_W = 16;
   localparam int RESULT_LINE_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic                     last;
      logic [RESULT_LINE_W-1:0] data;
   } line_t;

endpackage

// File: rtl/result_line_fifo.sv
// First-word-fall-through FIFO of packed result lines.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   flush_i        : synchronous clear of pointers and level (wins over push/pop)
//   push_i         : write push_line_i; ignored when full unless a pop happens too
//   pop_i          : drop the head line; ignored when empty
//   head_line_o    : current head, forced to zero while empty
//   full_o, empty_o, level_o : occupancy status
module result_line_fifo
   import gemm_pkg::*;
#(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  line_t         push_line_i,
   input  logic          pop_i,
   output line_t         head_line_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   line_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   // When full, the slot being written is the one the pop frees this cycle.
   assign do_push = push_i & (~full_o | do_pop);

   // Masked so the line bus reads as zero whenever nothing is queued.
   assign head_line_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o     = level_q;

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_line_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_q + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/result_packer_fifo.sv
// Packs the compute engine's FP16 result stream into 256-bit lines and
// queues them for writeback.
//   i_clk, i_reset_n      : clock, asynchronous active-low reset
//   i_tile_en             : start/abort pulse, latches i_total_results
//   i_result_data/valid   : one result per cycle from the engine
//   o_result_full/afull   : backpressure flags sampled by the engine
//   o_line_data/valid/last, i_line_ready : FWFT line handshake to writeback
//   o_tile_done           : pulse the cycle after the last line is taken
//   o_accept_count        : results accepted this tile (saturating)
//   o_overflow            : sticky, a line-completing result was dropped
//   o_level               : FIFO occupancy in lines
//
// state    | meaning
// ST_IDLE  | no tile active, incoming results ignored
// ST_PACK  | accepting results into the pack register
// ST_DRAIN | all results taken, waiting for the last line to be consumed
module result_packer_fifo
   import gemm_pkg::*;
#(
   parameter int LINE_DEPTH  = 16,
   parameter int AFULL_LINES = 2,
   parameter int ELEM_W      = RESULT_ELEM_W,
   parameter int LANES       = RESULT_LANES
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_tile_en,
   input  logic [15:0]                   i_total_results,
   input  logic [15:0]                   i_result_data,
   input  logic                          i_result_valid,
   output logic                          o_result_full,
   output logic                          o_result_afull,
   output logic [RESULT_LINE_W-1:0]      o_line_data,
   output logic                          o_line_valid,
   input  logic                          i_line_ready,
   output logic                          o_line_last,
   output logic                          o_tile_done,
   output logic [15:0]                   o_accept_count,
   output logic                          o_overflow,
   output logic [$clog2(LINE_DEPTH):0]   o_level
);

   localparam int LVL_W  = $clog2(LINE_DEPTH) + 1;
   localparam int LANE_W = $clog2(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   state_t                   state_q;
   logic [15:0]              total_q;
   logic [15:0]              count_q;
   logic [LANE_W-1:0]        lane_q;
   logic [LANE_W-1:0]        lane_d;
   logic [RESULT_LINE_W-1:0] pack_q;
   logic [RESULT_LINE_W-1:0] pack_merged;
   logic                     ovf_q;
   logic                     done_q;
   logic                     afull_q;
   logic                     afull_d;

   logic                     fifo_full;
   logic                     fifo_empty;
   logic [LVL_W-1:0]         fifo_level;
   logic [LVL_W-1:0]         level_d;
   line_t                    head_line;
   line_t                    push_line;

   logic                     pop;
   logic                     push;
   logic                     is_final;
   logic                     completes;
   logic                     blocked;
   logic                     offered;
   logic                     accept;
   logic                     drop;

   assign pop       = ~fifo_empty & i_line_ready;
   // count_q < total_q whenever packing, so the increment cannot wrap here.
   assign is_final  = (count_q + 16'd1) == total_q;
   assign completes = (lane_q == LAST_LANE) | is_final;
   assign blocked   = fifo_full & ~pop & completes;
   assign offered   = i_result_valid & (state_q == ST_PACK) & ~i_tile_en;
   assign accept    = offered & ~blocked;
   assign drop      = offered & blocked;
   assign push      = accept & completes;

   always_comb begin
      pack_merged = pack_q;
      pack_merged[int'(lane_q)*ELEM_W +: ELEM_W] = i_result_data;
   end

   assign push_line = '{last: is_final, data: pack_merged};

   always_comb begin
      lane_d = lane_q;
      if (i_tile_en || push) lane_d = '0;
      else if (accept)       lane_d = lane_q + LANE_W'(1);
   end

   // Almost-full is registered from next-state occupancy so it tracks
   // o_level and the pack register with no extra cycle of lag.
   always_comb begin
      int free_lines;
      level_d    = i_tile_en ? '0 : fifo_level + LVL_W'(push) - LVL_W'(pop);
      free_lines = LINE_DEPTH - int'(level_d) - ((lane_d != '0) ? 1 : 0);
      afull_d    = (free_lines <= AFULL_LINES);
   end

   result_line_fifo #(
      .DEPTH (LINE_DEPTH)
   ) u_fifo (
      .clk_i       (i_clk),
      .rst_n_i     (i_reset_n),
      .flush_i     (i_tile_en),
      .push_i      (push),
      .push_line_i (push_line),
      .pop_i       (pop),
      .head_line_o (head_line),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         total_q <= '0;
         count_q <= '0;
         lane_q  <= '0;
         pack_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         afull_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         afull_q <= afull_d;
         lane_q  <= lane_d;
         if (i_tile_en) begin
            // Start or abort: the aborted tile never reports done.
            total_q <= i_total_results;
            count_q <= '0;
            ovf_q   <= 1'b0;
            pack_q  <= '0;
            if (i_total_results == 16'd0) begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end else begin
               state_q <= ST_PACK;
            end
         end else begin
            if (accept) begin
               pack_q <= push ? '0 : pack_merged;
               if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            end
            if (drop) ovf_q <= 1'b1;
            case (state_q)
               ST_IDLE: ;
               ST_PACK: begin
                  if (accept && is_final) state_q <= ST_DRAIN;
               end
               ST_DRAIN: begin
                  if (pop && head_line.last) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_result_full  = fifo_full & (lane_q != '0);
   assign o_result_afull = afull_q;
   assign o_line_data    = head_line.data;
   assign o_line_last    = head_line.last;
   assign o_line_valid   = ~fifo_empty;
   assign o_tile_done    = done_q;
   assign o_accept_count = count_q;
   assign o_overflow     = ovf_q;
   assign o_level        = fifo_level;

endmodule

// File: tb/tb_result_packer_fifo.sv
module tb_result_packer_fifo;
   import gemm_pkg::*;

   localparam int DEPTH = 16;
   localparam int AFULL = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tile_en = 1'b0;
   logic [15:0]  total = '0;
   logic [15:0]  rdata = '0;
   logic         rvalid = 1'b0;
   logic         ready = 1'b0;
   logic         o_result_full, o_result_afull, o_line_valid, o_line_last;
   logic         o_tile_done, o_overflow;
   logic [255:0] o_line_data;
   logic [15:0]  o_accept_count;
   logic [4:0]   o_level;

   always #5 clk = ~clk;

   result_packer_fifo #(.LINE_DEPTH(DEPTH), .AFULL_LINES(AFULL)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_tile_en(tile_en), .i_total_results(total),
      .i_result_data(rdata), .i_result_valid(rvalid),
      .o_result_full(o_result_full), .o_result_afull(o_result_afull),
      .o_line_data(o_line_data), .o_line_valid(o_line_valid), .i_line_ready(ready),
      .o_line_last(o_line_last), .o_tile_done(o_tile_done),
      .o_accept_count(o_accept_count), .o_overflow(o_overflow), .o_level(o_level)
   );

   // Reference model: a queue of whole lines, a list of pending elements.
   typedef struct {
      bit           last;
      logic [255:0] data;
   } mline_t;

   mline_t      mq[$];
   logic [15:0] mpart[$];
   int          m_total, m_count;
   bit          m_active, m_ovf, m_done;
   int          checks = 0;
   int          failures = 0;

   function automatic void model_reset();
      mq.delete(); mpart.delete();
      m_total = 0; m_count = 0; m_active = 0; m_ovf = 0; m_done = 0;
   endfunction

   function automatic bit exp_afull();
      return (DEPTH - mq.size() - ((mpart.size() != 0) ? 1 : 0)) <= AFULL;
   endfunction

   function automatic bit exp_full();
      return (mq.size() == DEPTH) && (mpart.size() != 0);
   endfunction

   // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input bit en, input int tot, input bit v, input logic [15:0] d, input bit rdy);
      bit     pop, fin, completes;
      mline_t ln;
      @(negedge clk);
      tile_en = en; total = tot[15:0]; rvalid = v; rdata = d; ready = rdy;
      pop = (mq.size() > 0) && rdy;
      m_done = 0;
      if (en) begin
         mq.delete(); mpart.delete();
         m_count = 0; m_ovf = 0; m_total = tot;
         m_active = (tot != 0); m_done = (tot == 0);
      end else begin
         if (pop) begin
            if (mq[0].last) m_done = 1;
            void'(mq.pop_front());
         end
         if (m_active && v) begin
            fin = (m_count + 1 == m_total);
            completes = (mpart.size() == RESULT_LANES - 1) || fin;
            if (completes && mq.size() >= DEPTH) begin
               m_ovf = 1;
            end else begin
               mpart.push_back(d);
               m_count++;
               if (completes) begin
                  ln.data = '0;
                  foreach (mpart[k]) ln.data[k*16 +: 16] = mpart[k];
                  ln.last = fin;
                  mq.push_back(ln);
                  mpart.delete();
               end
               if (fin) m_active = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_line_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_line_valid); end
      checks++; if (o_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", o_level); end
      checks++; if (o_result_afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%0b exp=0", o_result_afull); end
      checks++; if (o_result_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", o_result_full); end
      checks++; if (o_tile_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", o_tile_done); end
      checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", o_overflow); end
      checks++; if (o_accept_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_accept_count); end
      checks++; if (o_line_data !== 256'd0 || o_line_last !== 1'b0) begin failures++; $display("FAIL reset_line got=%0h exp=0", o_line_data); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_tile();
      logic [255:0] cap[$];
      bit           lastv[$];
      int           dones = 0;
      step(1, 32, 0, 0, 1);
      for (int i = 0; i < 42; i++) begin
         if (o_line_valid) begin
            cap.push_back(o_line_data); lastv.push_back(o_line_last);
            checks++; if (o_line_data !== mq[0].data) begin failures++; $display("FAIL full_data got=%0h exp=%0h", o_line_data, mq[0].data); end
         end
         if (i < 32) step(0, 0, 1, 16'h3C00 + 16'(i), 1);
         else        step(0, 0, 0, 0, 1);
         if (o_tile_done) dones++;
         checks++; if (o_level !== 5'(mq.size())) begin failures++; $display("FAIL full_level got=%0d exp=%0d", o_level, mq.size()); end
      end
      checks++; if (cap.size() != 2) begin failures++; $display("FAIL full_lines got=%0d exp=2", cap.size()); end
      if (cap.size() == 2) begin
         checks++; if (cap[0][15:0] !== 16'h3C00) begin failures++; $display("FAIL full_l0_lane0 got=%0h exp=3c00", cap[0][15:0]); end
         checks++; if (cap[0][255:240] !== 16'h3C0F) begin failures++; $display("FAIL full_l0_lane15 got=%0h exp=3c0f", cap[0][255:240]); end
         checks++; if (lastv[0] !== 1'b0 || lastv[1] !== 1'b1) begin failures++; $display("FAIL full_last got=%0b%0b exp=01", lastv[0], lastv[1]); end
      end
      checks++; if (dones != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", dones); end
      checks++; if (o_accept_count !== 16'd32) begin failures++; $display("FAIL full_accept got=%0d exp=32", o_accept_count); end
   endtask

   task automatic test_partial();
      logic [255:0] l1 = '0;
      bit           l1_last = 0;
      int           nl = 0, dones = 0;
      logic [15:0]  expv;
      step(1, 20, 0, 0, 0);
      for (int i = 1; i <= 20; i++) step(0, 0, 1, 16'(i), 0);
      checks++; if (o_level !== 5'd2) begin failures++; $display("FAIL part_level got=%0d exp=2", o_level); end
      for (int i = 0; i < 6; i++) begin
         if (o_line_valid) begin
            if (nl == 1) begin l1 = o_line_data; l1_last = o_line_last; end
            nl++;
         end
         step(0, 0, 0, 0, 1);
         if (o_tile_done) dones++;
      end
      checks++; if (nl != 2) begin failures++; $display("FAIL part_lines got=%0d exp=2", nl); end
      for (int k = 0; k < 16; k++) begin
         expv = (k < 4) ? 16'(17 + k) : 16'd0;
         checks++; if (l1[k*16 +: 16] !== expv) begin failures++; $display("FAIL part_lane%0d got=%0h exp=%0h", k, l1[k*16 +: 16], expv); end
      end
      checks++; if (l1_last !== 1'b1) begin failures++; $display("FAIL part_last got=%0b exp=1", l1_last); end
      checks++; if (o_level !== 5'd0) begin failures++; $display("FAIL part_level_end got=%0d exp=0", o_level); end
      checks++; if (dones != 1) begin failures++; $display("FAIL part_done got=%0d exp=1", dones); end
   endtask

   task automatic test_afull_overflow();
      int first_lvl = -1;
      bit first_part = 0;
      int drained = 0;
      step(1, 512, 0, 0, 0);
      for (int i = 0; i < 275; i++) begin
         step(0, 0, 1, 16'($urandom), 0);
         if (o_result_afull && first_lvl < 0) begin first_lvl = o_level; first_part = (mpart.size() != 0); end
         checks++; if (o_result_afull !== exp_afull()) begin failures++; $display("FAIL af_afull i=%0d got=%0b exp=%0b", i, o_result_afull, exp_afull()); end
         checks++; if (o_result_full !== exp_full()) begin failures++; $display("FAIL af_full i=%0d got=%0b exp=%0b", i, o_result_full, exp_full()); end
         checks++; if (o_overflow !== m_ovf) begin failures++; $display("FAIL af_ovf i=%0d got=%0b exp=%0b", i, o_overflow, m_ovf); end
      end
      checks++; if (first_lvl != 13 || !first_part) begin failures++; $display("FAIL af_rise_level got=%0d partial=%0b exp=13 partial=1", first_lvl, first_part); end
      checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL af_ovf_set got=%0b exp=1", o_overflow); end
      checks++; if (o_level !== 5'd16) begin failures++; $display("FAIL af_level_full got=%0d exp=16", o_level); end
      checks++; if (o_accept_count !== 16'd271) begin failures++; $display("FAIL af_accept got=%0d exp=271", o_accept_count); end
      for (int i = 0; i < 24; i++) begin
         if (o_line_valid) begin
            drained++;
            checks++; if (o_line_data !== mq[0].data) begin failures++; $display("FAIL af_drain_data got=%0h exp=%0h", o_line_data, mq[0].data); end
         end
         step(0, 0, 0, 0, 1);
      end
      checks++; if (drained != 16) begin failures++; $display("FAIL af_drained got=%0d exp=16", drained); end
      checks++; if (o_level !== 5'd0 || o_overflow !== 1'b1) begin failures++; $display("FAIL af_after_drain level=%0d ovf=%0b exp=0/1", o_level, o_overflow); end
   endtask

   task automatic test_zero_total();
      step(1, 0, 0, 0, 1);
      checks++; if (o_tile_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%0b exp=1", o_tile_done); end
      checks++; if (o_overflow !== 1'b0 || o_accept_count !== 16'd0) begin failures++; $display("FAIL zero_clear ovf=%0b cnt=%0d exp=0/0", o_overflow, o_accept_count); end
      step(0, 0, 1, 16'h1234, 1);
      checks++; if (o_tile_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%0b exp=0", o_tile_done); end
      checks++; if (o_line_valid !== 1'b0 || o_accept_count !== 16'd0) begin failures++; $display("FAIL zero_idle valid=%0b cnt=%0d exp=0/0", o_line_valid, o_accept_count); end
   endtask

   task automatic test_abort();
      int nl = 0, dones = 0;
      bit lst = 0;
      step(1, 48, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 1, 16'($urandom), 0);
      checks++; if (o_level !== 5'd1 || o_accept_count !== 16'd20) begin failures++; $display("FAIL abort_pre level=%0d cnt=%0d exp=1/20", o_level, o_accept_count); end
      step(1, 16, 0, 0, 0);
      checks++; if (o_level !== 5'd0 || o_line_valid !== 1'b0 || o_accept_count !== 16'd0) begin failures++; $display("FAIL abort_flush level=%0d valid=%0b cnt=%0d exp=0/0/0", o_level, o_line_valid, o_accept_count); end
      checks++; if (o_tile_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0b exp=0", o_tile_done); end
      for (int i = 0; i < 24; i++) begin
         if (o_line_valid) begin
            nl++; lst = o_line_last;
            checks++; if (o_line_data !== mq[0].data) begin failures++; $display("FAIL abort_data got=%0h exp=%0h", o_line_data, mq[0].data); end
         end
         if (i < 16) step(0, 0, 1, 16'($urandom), 1);
         else        step(0, 0, 0, 0, 1);
         if (o_tile_done) dones++;
      end
      checks++; if (nl != 1 || lst !== 1'b1) begin failures++; $display("FAIL abort_lines got=%0d last=%0b exp=1/1", nl, lst); end
      checks++; if (dones != 1) begin failures++; $display("FAIL abort_done got=%0d exp=1", dones); end
   endtask

   task automatic test_reset_mid();
      int nl = 0, dones = 0;
      step(1, 64, 0, 0, 0);
      for (int i = 0; i < 48; i++) step(0, 0, 1, 16'($urandom), 0);
      checks++; if (o_level !== 5'd3) begin failures++; $display("FAIL rmid_pre got=%0d exp=3", o_level); end
      #2;
      rst_n = 1'b0; rvalid = 1'b0;
      model_reset();
      #1;
      checks++; if (o_line_valid !== 1'b0 || o_level !== 5'd0) begin failures++; $display("FAIL rmid_fifo valid=%0b level=%0d exp=0/0", o_line_valid, o_level); end
      checks++; if ({o_result_full, o_result_afull, o_overflow, o_tile_done} !== 4'b0) begin failures++; $display("FAIL rmid_flags got=%0b exp=0", {o_result_full, o_result_afull, o_overflow, o_tile_done}); end
      checks++; if (o_accept_count !== 16'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", o_accept_count); end
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 16, 0, 0, 1);
      for (int i = 0; i < 22; i++) begin
         if (o_line_valid) begin
            nl++;
            checks++; if (o_line_data !== mq[0].data || o_line_last !== mq[0].last) begin failures++; $display("FAIL rmid_data got=%0h exp=%0h", o_line_data, mq[0].data); end
         end
         if (i < 16) step(0, 0, 1, 16'($urandom), 1);
         else        step(0, 0, 0, 0, 1);
         if (o_tile_done) dones++;
      end
      checks++; if (nl != 1 || dones != 1) begin failures++; $display("FAIL rmid_after lines=%0d dones=%0d exp=1/1", nl, dones); end
   endtask

   task automatic test_random();
      int  tot, cyc;
      bit  seen, v, rdy;
      for (int t = 0; t < 4; t++) begin
         tot  = (t % 2 == 0) ? int'($urandom_range(1, 80)) : int'($urandom_range(200, 400));
         seen = 0;
         cyc  = 0;
         step(1, tot, 0, 0, 0);
         while (!seen && cyc < 4000) begin
            v   = ($urandom % 4) != 0;
            rdy = (t % 2 == 0) ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
            if (o_line_valid && rdy) begin
               checks++; if (o_line_data !== mq[0].data || o_line_last !== mq[0].last) begin failures++; $display("FAIL rnd_data t=%0d got=%0h exp=%0h", t, o_line_data, mq[0].data); end
            end
            step(0, 0, v, 16'($urandom), rdy);
            cyc++;
            if (o_tile_done) seen = 1;
            checks++; if (o_tile_done !== m_done) begin failures++; $display("FAIL rnd_done t=%0d got=%0b exp=%0b", t, o_tile_done, m_done); end
            checks++; if (o_level !== 5'(mq.size()) || o_line_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_level t=%0d got=%0d exp=%0d", t, o_level, mq.size()); end
            checks++; if (o_result_afull !== exp_afull() || o_result_full !== exp_full()) begin failures++; $display("FAIL rnd_flags t=%0d got=%0b%0b exp=%0b%0b", t, o_result_afull, o_result_full, exp_afull(), exp_full()); end
            checks++; if (o_accept_count !== 16'(m_count) || o_overflow !== m_ovf) begin failures++; $display("FAIL rnd_count t=%0d got=%0d/%0b exp=%0d/%0b", t, o_accept_count, o_overflow, m_count, m_ovf); end
         end
         checks++; if (!seen) begin failures++; $display("FAIL rnd_timeout t=%0d got=no_done exp=done", t); end
      end
   endtask

   initial begin
      test_reset();
      test_full_tile();
      test_partial();
      test_afull_overflow();
      test_zero_total();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
